// File: rtl/memory_store_align_if.sv
// Store-aligner bus: LSU request side plus data-memory write-beat side.
// master = request source / memory sink, slave = the aligner.
interface memory_store_align_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    localparam int BYTES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_data;
    logic              req_err;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [BYTES-1:0]  mem_strb;
    logic              mem_last;

    modport master (
        output req_valid, req_addr, req_size, req_data, mem_ready,
        input  req_ready, req_err, mem_valid, mem_addr, mem_data, mem_strb, mem_last
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_data, mem_ready,
        output req_ready, req_err, mem_valid, mem_addr, mem_data, mem_strb, mem_last
    );
endinterface

// File: rtl/memory_store_align.sv
// Registered store-data aligner: shifts an LSB-justified store to its byte
// lanes, builds byte strobes and splits line-crossing stores into two beats.
module memory_store_align #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    memory_store_align_if.slave  bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;

    logic [1:0]          state;
    logic [OFF_W-1:0]    off;
    logic [3:0]          n;
    logic                illegal;
    logic                split;
    logic                accept;
    logic                mem_fire;
    logic [DATA_W-1:0]   masked;
    logic [2*DATA_W-1:0] wide_data;
    logic [2*BYTES-1:0]  base_strb;
    logic [2*BYTES-1:0]  wide_strb;
    logic [ADDR_W-1:0]   base_addr;
    // Upper half of a split store, parked until beat 0 handshakes.
    logic [DATA_W-1:0]   hi_data;
    logic [BYTES-1:0]    hi_strb;

    // A new request can only enter when nothing is in flight or the final
    // beat of the current request leaves this cycle.
    assign bus.req_ready = (state == IDLE) ||
                           (bus.mem_valid && bus.mem_last && bus.mem_ready);
    assign accept   = bus.req_valid && bus.req_ready;
    assign mem_fire = bus.mem_valid && bus.mem_ready;

    // Lane placement: mask to n bytes, shift by the byte offset into a
    // double-width window whose halves become beat 0 and beat 1.
    always_comb begin
        off       = bus.req_addr[OFF_W-1:0];
        n         = 4'd1 << bus.req_size;
        illegal   = (int'(n) > BYTES);
        split     = (int'(off) + int'(n) > BYTES);
        masked    = '0;
        base_strb = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(n)) masked[8*i +: 8] = bus.req_data[8*i +: 8];
        end
        for (int i = 0; i < 2*BYTES; i++) begin
            base_strb[i] = (i < int'(n));
        end
        wide_data = {{DATA_W{1'b0}}, masked} << {off, 3'b000};
        wide_strb = base_strb << off;
        base_addr = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    // Beat sequencer: IDLE -> BEAT0 [-> BEAT1] -> IDLE, with back-to-back
    // reload when a request is accepted on the last-beat handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_data  <= '0;
            bus.mem_strb  <= '0;
            bus.mem_last  <= 1'b0;
            bus.req_err   <= 1'b0;
            hi_data       <= '0;
            hi_strb       <= '0;
        end else begin
            bus.req_err <= accept && illegal;
            if (state == BEAT0 && mem_fire && !bus.mem_last) begin
                // req_ready is low here, so no request can collide with beat 1.
                state        <= BEAT1;
                bus.mem_addr <= bus.mem_addr + ADDR_W'(BYTES);
                bus.mem_data <= hi_data;
                bus.mem_strb <= hi_strb;
                bus.mem_last <= 1'b1;
            end else if (accept && !illegal) begin
                state         <= BEAT0;
                bus.mem_valid <= 1'b1;
                bus.mem_addr  <= base_addr;
                bus.mem_data  <= wide_data[DATA_W-1:0];
                bus.mem_strb  <= wide_strb[BYTES-1:0];
                bus.mem_last  <= !split;
                hi_data       <= wide_data[2*DATA_W-1:DATA_W];
                hi_strb       <= wide_strb[2*BYTES-1:BYTES];
            end else if (accept || mem_fire) begin
                // Last beat gone (or an illegal request swallowed): go idle.
                state         <= IDLE;
                bus.mem_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/memory_store_align.md
# memory_store_align

Parametrised, registered store-data aligner that sits between the LSU store path and the data-memory write port. It accepts one LSB-justified store request per handshake and shifts it to its byte lane. It generates byte strobes and splits any store that crosses a DATA_W boundary into two aligned beats. It is the successor of the fixed 64-bit combinational store shifter, adding width parametrisation, strobes, misalignment splitting and valid/ready flow control.

## Interface
- DATA_W, 64: bus width in bits; power of two, 16..64. BYTES = DATA_W/8, OFF_W = log2(BYTES).
- ADDR_W, 64: address width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  byte address of the store.
- req_size  in  2  0=byte, 1=half, 2=word, 3=double.
- req_data  in  DATA_W  store data, LSB-justified; bits above the size are don't-care.
- req_err  out  1  one-cycle pulse: the accepted request had an illegal size.
- mem_valid  out  1  write beat valid.
- mem_ready  in  1  memory accepts the beat when mem_valid && mem_ready.
- mem_addr  out  ADDR_W  beat address, aligned to BYTES (low OFF_W bits 0).
- mem_data  out  DATA_W  lane-positioned write data.
- mem_strb  out  BYTES  byte write enables.
- mem_last  out  1  final beat of the current request.

## Operation
- States are IDLE, BEAT0 and BEAT1. All mem_* outputs and req_err are registered.
- On accept, compute the following:
  - off = req_addr[OFF_W-1:0] and n = 1<<req_size.
  - Mask the data to its low n bytes, with the upper bytes forced to 0.
  - Form the 2*DATA_W-bit value masked_data << (8*off) and the 2*BYTES-bit strobe ((1<<n)-1) << off.
  - split = (off + n > BYTES).
- Beat 0 carries the low halves at address {req_addr[ADDR_W-1:OFF_W], 0}. Beat 1, only if split, carries the high halves at beat-0 address + BYTES, wrapping modulo 2^ADDR_W.
- IDLE to BEAT0 on accept with a legal size. mem_valid goes to 1 and mem_last = !split.
- BEAT0 on handshake:
  - If split, go to BEAT1 with mem_last=1.
  - Otherwise, return to IDLE, or reload BEAT0 if a new request is accepted in the same cycle.
- BEAT1 on handshake: return to IDLE, or go to BEAT0 for a simultaneously accepted request.
- Ready rule: req_ready = (state==IDLE) || (mem_valid && mem_last && mem_ready). This is the only combinational input-to-output path.
- Illegal size (n > BYTES) handling:
  - The request is accepted and no beat is issued.
  - req_err pulses high the cycle after accept and the state stays IDLE.
  - If such a request is accepted during a last-beat handshake, the state goes to IDLE.
- While mem_valid && !mem_ready, mem_addr, mem_data, mem_strb and mem_last hold stable and req_ready is 0.
- Reset values (asynchronous, applied immediately when rst_n falls): state=IDLE, mem_valid=0, mem_addr=0, mem_data=0, mem_strb=0, mem_last=0, req_err=0.
- Reset mid-request drops any pending beat, including the second beat of a split. No partial beat is reissued after reset.

## Timing
- Latency: a request accepted on edge N presents beat 0 on mem_* after edge N; beat 1 follows the edge at which beat 0 handshakes.
- Throughput: one beat per cycle with mem_ready held high. Non-split stores sustain 1 request/cycle; split stores take 2 cycles each.
- mem_valid, once raised, stays high until handshake. It never drops without mem_ready, except on reset.
- req_err is high for exactly one cycle per illegal request and is never asserted together with mem_valid for that request.

## Test plan
- Aligned store, DATA_W=64: sd at addr 0x1000, data 0x1122334455667788, mem_ready=1. Expect 1 beat: addr 0x1000, data 0x1122334455667788, strb 0xFF, last=1, one cycle after accept.
- Byte lane placement: sb at addr 0x1003, data 0xFFFFFFFFFFFFFFAB. Expect data 0x00000000AB000000, strb 0x08, last=1.
- Split store: sw at addr 0x1006, data 0xDDCCBBAA. Expect 2 beats:
  - beat 0: addr 0x1000, data 0xBBAA000000000000, strb 0xC0, last=0;
  - beat 1: addr 0x1008, data 0x000000000000DDCC, strb 0x03, last=1.
- Split at the top of the address space: sh at addr 0xFFFFFFFFFFFFFFFF. Expect beat 1 addr wraps to 0x0000000000000000 with strb 0x01.
- Backpressure and throughput:
  - In the split case, hold mem_ready=0 for 3 cycles during beat 0. All mem_* must stay stable and req_ready=0. Beat 1 follows the release.
  - Back-to-back aligned sd stores with mem_ready=1 give one beat per cycle, with no bubble.
- Reset and illegal size:
  - Assert rst_n=0 one cycle after the beat-0 handshake of a split. mem_valid must drop to 0 immediately, and after release no beat 1 appears.
  - With DATA_W=32, size=3 is accepted, req_err pulses for 1 cycle, and mem_valid stays 0.
